fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Shares one pipelined single-precision adder between two requesters. Accepts operand pairs over per-requester valid/ready ports, issues them to the adder with a 1-bit tag, and steers each tagged result into that requester's response FIFO. Per-requester credit counters ensure a returning result always has a FIFO slot, so the adder pipeline never needs to stall. Sits between the datapath clients and the adder/normalization/rounding pipeline.

## Interface
- RQ_DEPTH, 4: entries in each response FIFO, and the maximum outstanding plus buffered results per requester (power of 2, ≥2).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid_0 / req_valid_1  in  1  operand pair valid.
- req_ready_0 / req_ready_1  out  1  operand pair accepted this cycle (combinational).
- req_a_0, req_b_0 / req_a_1, req_b_1  in  32  IEEE-754 single operands.
- add_valid  out  1  issue strobe to adder (registered).
- add_a, add_b  out  32  issued operands (registered).
- add_tag  out  1  requester index carried through the adder.
- add_res_valid  in  1  adder result strobe.
- add_res  in  32  adder result.
- add_res_ovf  in  1  adder overflow flag.
- add_res_tag  in  1  returned tag.
- rsp_valid_0 / rsp_valid_1  out  1  FIFO head valid.
- rsp_ready_0 / rsp_ready_1  in  1  consumer pops head.
- rsp_data_0 / rsp_data_1  out  32  head result.
- rsp_ovf_0 / rsp_ovf_1  out  1  head overflow flag.
- err  out  1  sticky: result arrived with no matching credit.

## Operation
- credit_i = outstanding_i + occupancy_i (width clog2(RQ_DEPTH)+1). Requester i is eligible when req_valid_i && credit_i < RQ_DEPTH.
- Arbitration: at most one grant per cycle. Round-robin pointer rr (reset 0) names the preferred requester. When both are eligible, grant rr, then set rr to the other requester. When one is eligible, grant it and set rr to the other. When neither is eligible, rr holds.
- req_ready_i = grant_i. It never depends on rsp_ready.
- On grant: next cycle add_valid=1, add_a/add_b = granted operands, add_tag = i, outstanding_i++. With no grant, add_valid=0; add_a/add_b/add_tag hold their last values.
- On add_res_valid: push {add_res_ovf, add_res} into FIFO[add_res_tag], outstanding[tag]--. If outstanding[tag]==0, drop the result and set err.
- Pop: rsp_valid_i && rsp_ready_i removes the head and decrements occupancy_i.
- Simultaneous events on one requester: issue, return and pop may occur in the same cycle. Compute credit_i as old + issue − pop. A return moves one unit from outstanding to occupancy, so the total is unchanged. The result must be exact.
- FIFO: circular buffer with wr/rd pointers that wrap modulo RQ_DEPTH. Overflow is impossible by construction of the credit check. Pop on empty is ignored.
- Reset mid-operation: pointers, counters, rr, FIFOs and err clear. The adder must be reset on the same rst. Any in-flight result returning afterwards finds zero credit, is dropped, and sets err.

## Timing
- Reset values: req_ready_* 0, add_valid 0, add_a/add_b 0, add_tag 0, rsp_valid_* 0, rsp_data_* 0, rsp_ovf_* 0, err 0.
- Request to issue: 1 cycle (accepted at edge N, add_valid high during N+1).
- Result to response: 1 cycle (add_res_valid at edge M, rsp_valid high during M+1 if the FIFO was empty).
- Sustained throughput: one issue per cycle total. With both requesters continuously eligible, grants alternate.
- rsp_data/rsp_ovf stay stable while rsp_valid && !rsp_ready.

## Configuration
- FP_ADD_ARB_FIXED_PRIO_EN defined: requester 0 always wins when both are eligible. rr is not implemented and requester 1 may starve.
- Not defined: round-robin as specified above.

## Test plan
- Single op: req_0 a=0x3F800000 b=0x40000000, adder model latency 3. Required: add_valid at +1 with tag 0; rsp_data_0=0x40400000, rsp_ovf_0=0 at +5.
- Contention: both valid for 8 cycles with rsp_ready high. Required: tags alternate 0,1,0,1…; each requester receives 4 results, in order.
- Credit limit: req_0 continuously valid, rsp_ready_0=0, RQ_DEPTH=4. Required: exactly 4 accepts, then req_ready_0=0. One pop allows exactly one more accept.
- Same-cycle issue+return+pop on requester 1 with credit=3. Required: credit remains 3; no data lost or duplicated.
- Overflow pass-through: a=b=0x7F7FFFFF, model sets ovf. Required: rsp_data_0=0x7F800000, rsp_ovf_0=1.
- Reset with 2 in flight, then the results return. Required: outputs at reset values, results dropped, err=1 until next rst. With macro defined, the contention test yields all grants to requester 0.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// fp_add_arbiter
// Shares one pipelined single-precision adder between two requesters.
// Operand pairs are accepted over per-requester valid/ready handshakes,
// issued to the adder with a 1-bit tag, and each returning result is
// steered into its requester's response FIFO. A per-requester credit
// (outstanding + buffered results) guarantees that every returning
// result has a FIFO slot, so the adder pipeline never stalls.
//
// Parameters:
//   RQ_DEPTH  response FIFO depth and credit limit per requester
//             (power of 2, >= 2)
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid_i/req_ready_i      operand handshake (ready is combinational)
//   req_a_i, req_b_i             IEEE-754 single operands
//   add_valid/add_a/add_b/add_tag   registered issue to the adder
//   add_res_valid/add_res/add_res_ovf/add_res_tag   adder result return
//   rsp_valid_i/rsp_ready_i      response FIFO head handshake
//   rsp_data_i, rsp_ovf_i        FIFO head result and overflow flag
//   err                          sticky: result returned without credit
// Configuration macro:
//   FP_ADD_ARB_FIXED_PRIO_EN     requester 0 always wins a tie
//                                (no round-robin pointer; requester 1
//                                may starve). Default: round-robin.
module fp_add_arbiter #(
  parameter int RQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_0,
  output logic        req_ready_0,
  input  logic [31:0] req_a_0,
  input  logic [31:0] req_b_0,
  input  logic        req_valid_1,
  output logic        req_ready_1,
  input  logic [31:0] req_a_1,
  input  logic [31:0] req_b_1,
  output logic        add_valid,
  output logic [31:0] add_a,
  output logic [31:0] add_b,
  output logic        add_tag,
  input  logic        add_res_valid,
  input  logic [31:0] add_res,
  input  logic        add_res_ovf,
  input  logic        add_res_tag,
  output logic        rsp_valid_0,
  input  logic        rsp_ready_0,
  output logic [31:0] rsp_data_0,
  output logic        rsp_ovf_0,
  output logic        rsp_valid_1,
  input  logic        rsp_ready_1,
  output logic [31:0] rsp_data_1,
  output logic        rsp_ovf_1,
  output logic        err
);

  localparam int PW = $clog2(RQ_DEPTH);
  localparam int CW = $clog2(RQ_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RQ_DEPTH);

  logic [CW-1:0] outstanding [2];
  logic [CW-1:0] occupancy   [2];
  logic [PW-1:0] wr_ptr      [2];
  logic [PW-1:0] rd_ptr      [2];
  logic [32:0]   fifo_mem    [2][RQ_DEPTH];

  logic [1:0]  req_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] req_a [2];
  logic [31:0] req_b [2];
  logic [1:0]  eligible;
  logic [1:0]  grant;
  logic [1:0]  ret;
  logic [1:0]  pop;
  logic        ret_drop;

`ifndef FP_ADD_ARB_FIXED_PRIO_EN
  logic rr;  // preferred requester on a tie
`endif

  assign req_valid = {req_valid_1, req_valid_0};
  assign rsp_ready = {rsp_ready_1, rsp_ready_0};
  assign req_a[0]  = req_a_0;
  assign req_a[1]  = req_a_1;
  assign req_b[0]  = req_b_0;
  assign req_b[1]  = req_b_1;

  // Eligibility, arbitration, result steering and pop decode.
  always_comb begin
    eligible = 2'b00;
    grant    = 2'b00;
    ret      = 2'b00;
    ret_drop = 1'b0;
    pop      = 2'b00;
    for (int i = 0; i < 2; i++) begin
      // credit = outstanding + occupancy never exceeds RQ_DEPTH, so it fits CW bits
      eligible[i] = req_valid[i] && ((outstanding[i] + occupancy[i]) < DEPTH_C);
      pop[i]      = (occupancy[i] != '0) && rsp_ready[i];
    end
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
    grant[0] = eligible[0];
    grant[1] = eligible[1] && !eligible[0];
`else
    if (eligible == 2'b11) begin
      grant = rr ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
`endif
    // Hold off handshakes while reset is applied so ready reads 0.
    if (rst) begin
      grant = 2'b00;
    end
    if (add_res_valid) begin
      if (outstanding[add_res_tag] != '0) begin
        ret[add_res_tag] = 1'b1;
      end else begin
        ret_drop = 1'b1;
      end
    end
  end

  assign req_ready_0 = grant[0];
  assign req_ready_1 = grant[1];

  // Per-requester counters, FIFO storage and pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        outstanding[i] <= '0;
        occupancy[i]   <= '0;
        wr_ptr[i]      <= '0;
        rd_ptr[i]      <= '0;
        for (int j = 0; j < RQ_DEPTH; j++) begin
          fifo_mem[i][j] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        // A return moves one credit unit from outstanding to occupancy.
        case ({grant[i], ret[i]})
          2'b10:   outstanding[i] <= outstanding[i] + CW'(1);
          2'b01:   outstanding[i] <= outstanding[i] - CW'(1);
          default: outstanding[i] <= outstanding[i];
        endcase
        case ({ret[i], pop[i]})
          2'b10:   occupancy[i] <= occupancy[i] + CW'(1);
          2'b01:   occupancy[i] <= occupancy[i] - CW'(1);
          default: occupancy[i] <= occupancy[i];
        endcase
        if (ret[i]) begin
          fifo_mem[i][wr_ptr[i]] <= {add_res_ovf, add_res};
          wr_ptr[i]              <= wr_ptr[i] + PW'(1);
        end
        if (pop[i]) begin
          rd_ptr[i] <= rd_ptr[i] + PW'(1);
        end
      end
    end
  end

  // Registered issue port; operands and tag hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      add_valid <= 1'b0;
      add_a     <= 32'd0;
      add_b     <= 32'd0;
      add_tag   <= 1'b0;
    end else begin
      add_valid <= |grant;
      if (|grant) begin
        add_a   <= grant[1] ? req_a[1] : req_a[0];
        add_b   <= grant[1] ? req_b[1] : req_b[0];
        add_tag <= grant[1];
      end
    end
  end

`ifndef FP_ADD_ARB_FIXED_PRIO_EN
  // Round-robin pointer: after any grant, prefer the other requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr <= 1'b0;
    end else if (|grant) begin
      rr <= grant[0];
    end
  end
`endif

  // Sticky error for a result that arrives with no outstanding credit.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ret_drop) begin
      err <= 1'b1;
    end
  end

  assign rsp_valid_0 = (occupancy[0] != '0);
  assign rsp_valid_1 = (occupancy[1] != '0);
  assign rsp_data_0  = fifo_mem[0][rd_ptr[0]][31:0];
  assign rsp_ovf_0   = fifo_mem[0][rd_ptr[0]][32];
  assign rsp_data_1  = fifo_mem[1][rd_ptr[1]][31:0];
  assign rsp_ovf_1   = fifo_mem[1][rd_ptr[1]][32];

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Testbench for fp_add_arbiter: a 3-stage behavioural adder closes the
// loop, and a queue-based reference model predicts grants, issued
// operands, FIFO contents and err every cycle. Directed phases cover the
// single op, contention, credit limit, same-cycle issue/return/pop,
// overflow pass-through and reset with results in flight, followed by a
// randomized phase.
module tb_fp_add_arbiter;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_0, req_valid_1, req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        add_valid, add_tag;
  logic [31:0] add_a, add_b;
  logic        add_res_valid, add_res_ovf, add_res_tag;
  logic [31:0] add_res;
  logic        rsp_valid_0, rsp_ready_0, rsp_ovf_0;
  logic        rsp_valid_1, rsp_ready_1, rsp_ovf_1;
  logic [31:0] rsp_data_0, rsp_data_1;
  logic        err;

  always #5 clk = ~clk;

  fp_add_arbiter #(.RQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_0(req_valid_0), .req_ready_0(req_ready_0), .req_a_0(req_a_0), .req_b_0(req_b_0),
    .req_valid_1(req_valid_1), .req_ready_1(req_ready_1), .req_a_1(req_a_1), .req_b_1(req_b_1),
    .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_tag(add_tag),
    .add_res_valid(add_res_valid), .add_res(add_res), .add_res_ovf(add_res_ovf),
    .add_res_tag(add_res_tag),
    .rsp_valid_0(rsp_valid_0), .rsp_ready_0(rsp_ready_0), .rsp_data_0(rsp_data_0), .rsp_ovf_0(rsp_ovf_0),
    .rsp_valid_1(rsp_valid_1), .rsp_ready_1(rsp_ready_1), .rsp_data_1(rsp_data_1), .rsp_ovf_1(rsp_ovf_1),
    .err(err)
  );

  // ---------------- behavioural single-precision add ----------------
  function automatic real f2r(input logic [31:0] x);
    real v;
    int  e;
    e = int'(x[30:23]);
    if (e == 0) return 0.0;
    v = 1.0 + real'(int'(x[22:0])) / 8388608.0;
    for (int k = 127; k < e; k++) v = v * 2.0;
    for (int k = e; k < 127; k++) v = v / 2.0;
    return x[31] ? -v : v;
  endfunction

  // Returns {ovf, result}; truncating rounding, overflow gives infinity.
  function automatic logic [32:0] fadd(input logic [31:0] a, input logic [31:0] b);
    real  v;
    int   e;
    int   frac;
    logic s;
    v = f2r(a) + f2r(b);
    if (v == 0.0) return 33'd0;
    s = (v < 0.0);
    if (s) v = -v;
    e = 127;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    if (e >= 255) return {1'b1, s, 8'hFF, 23'd0};
    if (e <= 0) return {1'b0, s, 31'd0};
    frac = $rtoi((v - 1.0) * 8388608.0);
    return {1'b0, s, e[7:0], frac[22:0]};
  endfunction

  // 3-cycle adder model; deliberately not reset so in-flight results can
  // return after a mid-operation reset.
  logic [34:0] pipe [3] = '{default: 35'd0};
  always @(posedge clk) begin
    pipe[0] <= {add_valid, add_tag, fadd(add_a, add_b)};
    pipe[1] <= pipe[0];
    pipe[2] <= pipe[1];
  end
  assign add_res_valid = pipe[2][34];
  assign add_res_tag   = pipe[2][33];
  assign add_res_ovf   = pipe[2][32];
  assign add_res       = pipe[2][31:0];

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_out0, m_out1;
  logic [32:0] q_fly0[$], q_fly1[$], q_rsp0[$], q_rsp1[$];
  bit          m_rr, m_err, m_add_valid, m_add_tag;
  logic [31:0] m_add_a, m_add_b;
  bit          mg0, mg1;
  int          acc0, acc1, pop0, pop1;

  task automatic model_reset();
    m_out0 = 0; m_out1 = 0;
    q_fly0.delete(); q_fly1.delete(); q_rsp0.delete(); q_rsp1.delete();
    m_rr = 1'b0; m_err = 1'b0;
    m_add_valid = 1'b0; m_add_tag = 1'b0; m_add_a = 32'd0; m_add_b = 32'd0;
  endtask

  task automatic model_check();
    bit e0, e1;
    e0 = !rst && req_valid_0 && (m_out0 + q_rsp0.size() < DEPTH);
    e1 = !rst && req_valid_1 && (m_out1 + q_rsp1.size() < DEPTH);
`ifdef FP_ADD_ARB_FIXED_PRIO_EN
    mg0 = e0;
    mg1 = e1 && !e0;
`else
    if (e0 && e1) begin
      mg0 = (m_rr == 1'b0);
      mg1 = (m_rr == 1'b1);
    end else begin
      mg0 = e0;
      mg1 = e1;
    end
`endif
    check_eq("req_ready_0", req_ready_0, mg0);
    check_eq("req_ready_1", req_ready_1, mg1);
    check_eq("add_valid", add_valid, m_add_valid);
    check_eq("add_a", add_a, m_add_a);
    check_eq("add_b", add_b, m_add_b);
    check_eq("add_tag", add_tag, m_add_tag);
    check_eq("err", err, m_err);
    check_eq("rsp_valid_0", rsp_valid_0, q_rsp0.size() > 0);
    check_eq("rsp_valid_1", rsp_valid_1, q_rsp1.size() > 0);
    if (q_rsp0.size() > 0) check_eq("rsp_head_0", {rsp_ovf_0, rsp_data_0}, q_rsp0[0]);
    if (q_rsp1.size() > 0) check_eq("rsp_head_1", {rsp_ovf_1, rsp_data_1}, q_rsp1[0]);
  endtask

  task automatic model_update();
    bit p0, p1;
    if (rst) begin
      model_reset();
    end else begin
      p0 = (q_rsp0.size() > 0) && rsp_ready_0;
      p1 = (q_rsp1.size() > 0) && rsp_ready_1;
      if (p0) void'(q_rsp0.pop_front());
      if (p1) void'(q_rsp1.pop_front());
      if (add_res_valid) begin
        if (add_res_tag == 1'b0) begin
          if (m_out0 > 0) begin q_rsp0.push_back(q_fly0.pop_front()); m_out0--; end
          else m_err = 1'b1;
        end else begin
          if (m_out1 > 0) begin q_rsp1.push_back(q_fly1.pop_front()); m_out1--; end
          else m_err = 1'b1;
        end
      end
      if (mg0) begin
        q_fly0.push_back(fadd(req_a_0, req_b_0));
        m_out0++;
        m_add_valid = 1'b1; m_add_a = req_a_0; m_add_b = req_b_0; m_add_tag = 1'b0; m_rr = 1'b1;
      end else if (mg1) begin
        q_fly1.push_back(fadd(req_a_1, req_b_1));
        m_out1++;
        m_add_valid = 1'b1; m_add_a = req_a_1; m_add_b = req_b_1; m_add_tag = 1'b1; m_rr = 1'b0;
      end else begin
        m_add_valid = 1'b0;
      end
    end
  endtask

  // One clock: inputs are already driven (we sit just after a negedge).
  task automatic cycle();
    #1;
    model_check();
    if (req_ready_0) acc0++;
    if (req_ready_1) acc1++;
    if (rsp_valid_0 && rsp_ready_0) pop0++;
    if (rsp_valid_1 && rsp_ready_1) pop1++;
    model_update();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_fp();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
  endfunction

  task automatic rand_ops();
    req_a_0 = rand_fp(); req_b_0 = rand_fp();
    req_a_1 = rand_fp(); req_b_1 = rand_fp();
  endtask

  task automatic idle(input int n);
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    acc0 = 0; acc1 = 0; pop0 = 0; pop1 = 0;
  endtask

  // Issue one op on requester 0 and check the head 5 cycles later.
  task automatic single_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_d, input logic exp_o);
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    req_valid_0 = 1'b1; req_a_0 = a; req_b_0 = b;
    cycle();
    req_valid_0 = 1'b0;
    #1;
    check_eq({name, "_issue_valid"}, add_valid, 1'b1);
    check_eq({name, "_issue_tag"}, add_tag, 1'b0);
    repeat (4) cycle();
    #1;
    check_eq({name, "_rsp_valid"}, rsp_valid_0, 1'b1);
    check_eq({name, "_rsp_data"}, rsp_data_0, exp_d);
    check_eq({name, "_rsp_ovf"}, rsp_ovf_0, exp_o);
    rsp_ready_0 = 1'b1;
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    req_a_0 = 32'd0; req_b_0 = 32'd0; req_a_1 = 32'd0; req_b_1 = 32'd0;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    acc0 = 0; acc1 = 0; pop0 = 0; pop1 = 0;
    repeat (5) @(negedge clk);
    model_reset();
    do_reset();
    #1;
    check_eq("reset_rsp_data_0", rsp_data_0, 32'd0);
    check_eq("reset_rsp_data_1", rsp_data_1, 32'd0);
    check_eq("reset_rsp_ovf_0", rsp_ovf_0, 1'b0);
    check_eq("reset_add_a", add_a, 32'd0);

    // single op and overflow pass-through
    single_op("single", 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0);
    idle(8);
    single_op("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1);
    idle(8);

    // contention: both valid for 8 cycles
    do_reset();
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      req_valid_0 = 1'b1; req_valid_1 = 1'b1;
      rand_ops();
      cycle();
    end
    idle(12);
    check_eq("contention_total", acc0 + acc1, 8);
`ifndef FP_ADD_ARB_FIXED_PRIO_EN
    check_eq("contention_acc0", acc0, 4);
    check_eq("contention_acc1", acc1, 4);
    check_eq("contention_pop0", pop0, 4);
    check_eq("contention_pop1", pop1, 4);
`endif

    // credit limit on requester 0
    do_reset();
    rsp_ready_0 = 1'b0;
    req_valid_0 = 1'b1;
    for (int k = 0; k < 12; k++) begin rand_ops(); cycle(); end
    #1;
    check_eq("credit_acc", acc0, 4);
    check_eq("credit_ready_low", req_ready_0, 1'b0);
    rsp_ready_0 = 1'b1;
    cycle();
    rsp_ready_0 = 1'b0;
    for (int k = 0; k < 6; k++) begin rand_ops(); cycle(); end
    check_eq("credit_acc_after_pop", acc0, 5);
    idle(12);

    // same-cycle issue + return + pop on requester 1 at credit 3
    do_reset();
    rsp_ready_1 = 1'b0;
    for (int k = 0; k < 3; k++) begin req_valid_1 = 1'b1; rand_ops(); cycle(); end
    req_valid_1 = 1'b0;
    repeat (2) cycle();
    req_valid_1 = 1'b1; rsp_ready_1 = 1'b1; rand_ops();
    #1;
    check_eq("same_ret_valid", add_res_valid, 1'b1);
    check_eq("same_ret_tag", add_res_tag, 1'b1);
    check_eq("same_rsp_valid", rsp_valid_1, 1'b1);
    check_eq("same_ready", req_ready_1, 1'b1);
    cycle();
    req_valid_1 = 1'b0; rsp_ready_1 = 1'b0;
    cycle();
    idle(12);
    check_eq("same_acc1", acc1, 4);
    check_eq("same_pop1", pop1, 4);

    // reset with two results in flight
    do_reset();
    req_valid_0 = 1'b1;
    rand_ops(); cycle();
    rand_ops(); cycle();
    req_valid_0 = 1'b0;
    do_reset();
    #1;
    check_eq("flight_err_cleared", err, 1'b0);
    check_eq("flight_add_valid", add_valid, 1'b0);
    repeat (3) cycle();
    #1;
    check_eq("flight_err_set", err, 1'b1);
    check_eq("flight_rsp_valid_0", rsp_valid_0, 1'b0);
    idle(6);
    #1;
    check_eq("flight_err_sticky", err, 1'b1);
    do_reset();
    #1;
    check_eq("flight_err_reset", err, 1'b0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      req_valid_0 = ($urandom_range(0, 9) < 7);
      req_valid_1 = ($urandom_range(0, 9) < 7);
      rsp_ready_0 = ($urandom_range(0, 9) < 6);
      rsp_ready_1 = ($urandom_range(0, 9) < 6);
      rand_ops();
      cycle();
    end
    idle(12);
    check_eq("final_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
